// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file and its read ports.
package gpr_pkg;

  // Default geometry of the datapath register file.
  localparam int GPR_WIDTH = 32;
  localparam int GPR_DEPTH = 16;

  // Register index that is hardwired to zero when ZERO_REG is enabled.
  localparam int unsigned REG_ZERO = 0;

  // True when addr names a register that can be written or locked:
  // it must exist, and must not be the hardwired zero register.
  function automatic logic gpr_addr_valid(input logic [31:0] addr,
                                          input logic [31:0] depth,
                                          input logic        zero_reg);
    return (addr < depth) && !(zero_reg && (addr == REG_ZERO));
  endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One registered read port of gpr_file: selects a register (or the
// write data in flight to the same address) and reports whether the
// value is final or still owed by an outstanding destination lock.
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int WIDTH    = GPR_WIDTH,
  parameter int DEPTH    = GPR_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] regs [DEPTH],
  input  logic             wt_hit,
  input  logic [AW-1:0]    wt_addr,
  input  logic [WIDTH-1:0] wt_data,
  input  logic [DEPTH-1:0] pending_next,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  logic             addr_ok;
  logic [WIDTH-1:0] data_next;
  logic             ready_next;

  // Address 0 (with ZERO_REG) and out-of-range addresses read as a
  // constant zero that is always ready.
  assign addr_ok = gpr_addr_valid(32'(addr), 32'(DEPTH), ZERO_REG);

  // Select the value to capture: same-cycle write wins over the array.
  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    data_next  = '0;
    ready_next = 1'b1;
    if (addr_ok) begin
      if (wt_hit && (wt_addr == addr)) begin
        data_next = wt_data;
      end else begin
        data_next = regs[addr];
      end
      ready_next = ~pending_next[addr];
    end
  end

  // Capture on a read request; hold the previous result otherwise.
  // NOTE: flops are written with <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      ready <= 1'b1;
    end else if (en) begin
      data  <= data_next;
      ready <= ready_next;
    end
  end

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file: one write port, two registered read
// ports with write bypass, a write-through capture port and a per-register
// pending scoreboard used by the issue stage to track destinations.
module gpr_file
  import gpr_pkg::*;
#(
  parameter int WIDTH    = GPR_WIDTH,
  parameter int DEPTH    = GPR_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  // write port
  input  logic             wt_en,
  input  logic [AW-1:0]    wt_addr,
  input  logic [WIDTH-1:0] wt_data,
  // write-through capture port
  input  logic             through_en,
  output logic [WIDTH-1:0] through_data,
  // read port A
  input  logic             rd_a_en,
  input  logic [AW-1:0]    rd_a_addr,
  output logic [WIDTH-1:0] rd_a_data,
  output logic             rd_a_ready,
  // read port B
  input  logic             rd_b_en,
  input  logic [AW-1:0]    rd_b_addr,
  output logic [WIDTH-1:0] rd_b_data,
  output logic             rd_b_ready,
  // scoreboard
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  output logic             lock_busy,
  output logic [DEPTH-1:0] pending
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending_next;
  logic             wt_ok;
  logic             wt_hit;
  logic             lock_ok;
  logic             lock_pend;
  logic             lock_take;

  // A normal write only lands on an existing, writable register;
  // through mode diverts the data away from the array entirely.
  assign wt_ok  = gpr_addr_valid(32'(wt_addr), 32'(DEPTH), ZERO_REG);
  assign wt_hit = wt_en & ~through_en & wt_ok;

  // Locks outside the lockable set are dropped silently (never busy).
  assign lock_ok = gpr_addr_valid(32'(lock_addr), 32'(DEPTH), ZERO_REG);

  // Pending state of the lock target, forced low for ignored targets.
  always_comb begin
    lock_pend = 1'b0;
    if (lock_ok) begin
      lock_pend = pending[lock_addr];
    end
  end

  // A write retiring the same register this cycle frees it for the new lock.
  assign lock_busy = lock_en & lock_pend & ~(wt_hit & (wt_addr == lock_addr));
  assign lock_take = lock_en & lock_ok & ~lock_busy;

  // Next scoreboard: retire the written register, then claim the locked one,
  // so a simultaneous write and lock of the same register ends pending.
  always_comb begin
    pending_next = pending;
    if (wt_hit) begin
      pending_next[wt_addr] = 1'b0;
    end
    if (lock_take) begin
      pending_next[lock_addr] = 1'b1;
    end
  end

  // Register array update.
  // NOTE: the array is plain flops, not a RAM macro, and must read as zero after reset, so every entry is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wt_hit) begin
      regs[wt_addr] <= wt_data;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Write-through capture; holds whenever through mode is not requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      through_data <= '0;
    end else if (wt_en && through_en) begin
      through_data <= wt_data;
    end
  end

  gpr_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_read_a (
    .clk          (clk),
    .rst          (rst),
    .en           (rd_a_en),
    .addr         (rd_a_addr),
    .regs         (regs),
    .wt_hit       (wt_hit),
    .wt_addr      (wt_addr),
    .wt_data      (wt_data),
    .pending_next (pending_next),
    .data         (rd_a_data),
    .ready        (rd_a_ready)
  );

  gpr_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_read_b (
    .clk          (clk),
    .rst          (rst),
    .en           (rd_b_en),
    .addr         (rd_b_addr),
    .regs         (regs),
    .wt_hit       (wt_hit),
    .wt_addr      (wt_addr),
    .wt_data      (wt_data),
    .pending_next (pending_next),
    .data         (rd_b_data),
    .ready        (rd_b_ready)
  );

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file (12 registers, zero register enabled):
// directed scenarios followed by random traffic, all checked against a
// behavioural model of registers, scoreboard and port outputs.
module tb_gpr_file;

  localparam int WIDTH = 32;
  localparam int DEPTH = 12;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             wt_en;
  logic [AW-1:0]    wt_addr;
  logic [WIDTH-1:0] wt_data;
  logic             through_en;
  logic [WIDTH-1:0] through_data;
  logic             rd_a_en;
  logic [AW-1:0]    rd_a_addr;
  logic [WIDTH-1:0] rd_a_data;
  logic             rd_a_ready;
  logic             rd_b_en;
  logic [AW-1:0]    rd_b_addr;
  logic [WIDTH-1:0] rd_b_data;
  logic             rd_b_ready;
  logic             lock_en;
  logic [AW-1:0]    lock_addr;
  logic             lock_busy;
  logic [DEPTH-1:0] pending;

  gpr_file #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wt_en        (wt_en),
    .wt_addr      (wt_addr),
    .wt_data      (wt_data),
    .through_en   (through_en),
    .through_data (through_data),
    .rd_a_en      (rd_a_en),
    .rd_a_addr    (rd_a_addr),
    .rd_a_data    (rd_a_data),
    .rd_a_ready   (rd_a_ready),
    .rd_b_en      (rd_b_en),
    .rd_b_addr    (rd_b_addr),
    .rd_b_data    (rd_b_data),
    .rd_b_ready   (rd_b_ready),
    .lock_en      (lock_en),
    .lock_addr    (lock_addr),
    .lock_busy    (lock_busy),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_regs [DEPTH];
  bit               m_pend [DEPTH];
  logic [WIDTH-1:0] m_through;
  logic [WIDTH-1:0] m_a_data;
  logic [WIDTH-1:0] m_b_data;
  bit               m_a_ready;
  bit               m_b_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Registers 1..DEPTH-1 exist and are writable; 0 is hardwired zero.
  function automatic bit real_reg(input int a);
    return (a >= 1) && (a < DEPTH);
  endfunction

  function automatic logic [DEPTH-1:0] m_pend_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_through = '0;
    m_a_data  = '0;
    m_b_data  = '0;
    m_a_ready = 1'b1;
    m_b_ready = 1'b1;
  endtask

  task automatic read_model(input int addr, input bit wr, input int wa,
                            input logic [WIDTH-1:0] wd, input bit pn [DEPTH],
                            output logic [WIDTH-1:0] d, output bit r);
    if (!real_reg(addr)) begin
      d = '0;
      r = 1'b1;
    end else begin
      d = (wr && wa == addr) ? wd : m_regs[addr];
      r = !pn[addr];
    end
  endtask

  task automatic idle();
    wt_en      = 1'b0;
    wt_addr    = '0;
    wt_data    = '0;
    through_en = 1'b0;
    rd_a_en    = 1'b0;
    rd_a_addr  = '0;
    rd_b_en    = 1'b0;
    rd_b_addr  = '0;
    lock_en    = 1'b0;
    lock_addr  = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".a_data"},  64'(rd_a_data),    64'(m_a_data));
    check({tag, ".a_ready"}, 64'(rd_a_ready),   64'(m_a_ready));
    check({tag, ".b_data"},  64'(rd_b_data),    64'(m_b_data));
    check({tag, ".b_ready"}, 64'(rd_b_ready),   64'(m_b_ready));
    check({tag, ".through"}, 64'(through_data), 64'(m_through));
    check({tag, ".pending"}, 64'(pending),      64'(m_pend_vec()));
  endtask

  // Called at a falling edge with inputs already driven: checks the
  // combinational busy flag, advances the model, clocks, checks outputs.
  task automatic cycle(input string tag);
    int               wa, la;
    bit               wr, busy;
    bit               pn [DEPTH];
    logic [WIDTH-1:0] wd;
    #1;
    wa = int'(wt_addr);
    la = int'(lock_addr);
    wd = wt_data;
    wr = wt_en && !through_en && real_reg(wa);
    busy = lock_en && real_reg(la) && m_pend[la] && !(wr && wa == la);
    check({tag, ".busy"}, 64'(lock_busy), 64'(busy));
    pn = m_pend;
    if (wr) pn[wa] = 1'b0;
    if (lock_en && real_reg(la) && !busy) pn[la] = 1'b1;
    if (rd_a_en) read_model(int'(rd_a_addr), wr, wa, wd, pn, m_a_data, m_a_ready);
    if (rd_b_en) read_model(int'(rd_b_addr), wr, wa, wd, pn, m_b_data, m_b_ready);
    if (wr) m_regs[wa] = wd;
    if (wt_en && through_en) m_through = wd;
    m_pend = pn;
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".pending"}, 64'(pending),      64'(0));
    check({tag, ".a_data"},  64'(rd_a_data),    64'(0));
    check({tag, ".a_ready"}, 64'(rd_a_ready),   64'(1));
    check({tag, ".b_data"},  64'(rd_b_data),    64'(0));
    check({tag, ".b_ready"}, 64'(rd_b_ready),   64'(1));
    check({tag, ".through"}, 64'(through_data), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Read right after reset.
    rd_a_en = 1'b1; rd_a_addr = AW'(5);
    cycle("rd_after_rst");
    check("rd5_data", 64'(rd_a_data), 64'(0));

    // Write r3, then read it on both ports.
    idle(); wt_en = 1'b1; wt_addr = AW'(3); wt_data = 32'hDEAD_BEEF;
    cycle("wr_r3");
    idle(); rd_a_en = 1'b1; rd_a_addr = AW'(3); rd_b_en = 1'b1; rd_b_addr = AW'(3);
    cycle("rd_r3");
    check("r3_a", 64'(rd_a_data), 64'h0000_0000_DEAD_BEEF);
    check("r3_b", 64'(rd_b_data), 64'h0000_0000_DEAD_BEEF);

    // Same-cycle bypass.
    idle(); wt_en = 1'b1; wt_addr = AW'(7); wt_data = 32'h1234_5678;
    rd_a_en = 1'b1; rd_a_addr = AW'(7);
    cycle("bypass_r7");
    check("bypass_data", 64'(rd_a_data), 64'h0000_0000_1234_5678);

    // Zero register ignores writes.
    idle(); wt_en = 1'b1; wt_addr = AW'(0); wt_data = 32'hFFFF_FFFF;
    cycle("wr_r0");
    idle(); rd_a_en = 1'b1; rd_a_addr = AW'(0);
    cycle("rd_r0");
    check("r0_data", 64'(rd_a_data), 64'(0));

    // Lock r4, read it back as not ready.
    idle(); lock_en = 1'b1; lock_addr = AW'(4);
    cycle("lock_r4");
    check("pend4_set", 64'(pending[4]), 64'(1));
    idle(); rd_a_en = 1'b1; rd_a_addr = AW'(4);
    cycle("rd_r4_locked");
    check("r4_not_ready", 64'(rd_a_ready), 64'(0));

    // Second lock is busy and changes nothing.
    idle(); lock_en = 1'b1; lock_addr = AW'(4);
    #1 check("lock_busy_again", 64'(lock_busy), 64'(1));
    cycle("relock_r4");
    check("pend4_still", 64'(pending[4]), 64'(1));

    // Write retires the lock.
    idle(); wt_en = 1'b1; wt_addr = AW'(4); wt_data = 32'h0000_0044;
    cycle("wr_r4");
    check("pend4_clr", 64'(pending[4]), 64'(0));

    // Lock r4 again, then write and relock it in the same cycle.
    idle(); lock_en = 1'b1; lock_addr = AW'(4);
    cycle("lock_r4_b");
    idle(); wt_en = 1'b1; wt_addr = AW'(4); wt_data = 32'h0000_0444;
    lock_en = 1'b1; lock_addr = AW'(4);
    #1 check("wr_lock_busy", 64'(lock_busy), 64'(0));
    cycle("wr_lock_r4");
    check("pend4_wr_lock", 64'(pending[4]), 64'(1));

    // Through mode leaves array and scoreboard alone.
    idle(); wt_en = 1'b1; through_en = 1'b1; wt_addr = AW'(2); wt_data = 32'hA5A5_A5A5;
    cycle("through");
    check("through_data", 64'(through_data), 64'h0000_0000_A5A5_A5A5);
    check("pend2_through", 64'(pending[2]), 64'(0));
    idle(); rd_a_en = 1'b1; rd_a_addr = AW'(2);
    cycle("rd_r2");
    check("r2_unchanged", 64'(rd_a_data), 64'(0));

    // Out-of-range write, lock and read.
    idle(); wt_en = 1'b1; wt_addr = AW'(13); wt_data = 32'h1313_1313;
    lock_en = 1'b1; lock_addr = AW'(13);
    cycle("wr_oor");
    idle(); rd_a_en = 1'b1; rd_a_addr = AW'(13); rd_b_en = 1'b1; rd_b_addr = AW'(13);
    cycle("rd_oor");
    check("oor_data", 64'(rd_a_data), 64'(0));
    check("oor_ready", 64'(rd_a_ready), 64'(1));

    // Asynchronous reset between edges while traffic is active.
    idle(); wt_en = 1'b1; wt_addr = AW'(5); wt_data = 32'h5555_5555;
    lock_en = 1'b1; lock_addr = AW'(6);
    rd_a_en = 1'b1; rd_a_addr = AW'(3);
    #2 rst = 1'b1;
    #1 check_reset_state("mid_reset");
    model_reset();
    idle();
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i += 2) begin
      idle();
      rd_a_en = 1'b1; rd_a_addr = AW'(i);
      rd_b_en = 1'b1; rd_b_addr = AW'(i + 1);
      cycle("post_reset_rd");
    end

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      wt_en      = ($urandom_range(0, 1) == 1);
      through_en = ($urandom_range(0, 3) == 0);
      wt_addr    = AW'($urandom_range(0, 15));
      wt_data    = $urandom;
      rd_a_en    = ($urandom_range(0, 3) != 0);
      rd_a_addr  = AW'($urandom_range(0, 15));
      rd_b_en    = ($urandom_range(0, 3) != 0);
      rd_b_addr  = ($urandom_range(0, 3) == 0) ? rd_a_addr : AW'($urandom_range(0, 15));
      lock_en    = ($urandom_range(0, 2) == 0);
      lock_addr  = ($urandom_range(0, 3) == 0) ? wt_addr : AW'($urandom_range(0, 15));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- Parametrised general-purpose register file: DEPTH registers of WIDTH bits, one write port, two independent read ports (A, B) and a write-through capture port (C).
- Replaces per-register instances in the datapath.
- Adds write-to-read bypass, an optional hardwired zero register, and a per-register pending scoreboard so the issue stage can lock a destination and detect read-after-write hazards.
- All outputs are driven muxed values; the block has no tri-state outputs.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 16, number of registers (>=2; need not be a power of two).
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and never goes pending.
- AW, $clog2(DEPTH), address width (localparam, derived).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- wt_en, input, 1, write request.
- wt_addr, input, AW, write address.
- wt_data, input, WIDTH, write data.
- through_en, input, 1, with wt_en: redirect the write to port C instead of the array.
- through_data, output, WIDTH, registered capture of wt_data in through mode.
- rd_a_en, input, 1, read request, port A.
- rd_a_addr, input, AW, read address, port A.
- rd_a_data, output, WIDTH, registered read data, port A.
- rd_a_ready, output, 1, 1 = the value read was not pending.
- rd_b_en, rd_b_addr, rd_b_data, rd_b_ready: identical to port A.
- lock_en, input, 1, mark lock_addr pending (destination issued).
- lock_addr, input, AW, register to lock.
- lock_busy, output, 1, combinational: lock rejected because the target is already pending.
- pending, output, DEPTH, current scoreboard vector.

Behaviour:
- Reset (rst=1, async): all registers 0, pending 0, rd_a_data/rd_b_data 0, rd_a_ready/rd_b_ready 1, through_data 0. Reset asserted mid-operation discards in-flight writes and locks.
- Write (wt_en=1, through_en=0): at the clk edge, reg[wt_addr] <= wt_data and pending[wt_addr] <= 0.
  - Ignored if ZERO_REG and wt_addr==0.
  - Ignored if wt_addr>=DEPTH.
- Through mode (wt_en=1, through_en=1): through_data <= wt_data at the edge. Array and pending are unchanged. through_data holds in all other cycles.
- Read latency is 1 cycle. When rd_x_en=1, at the edge:
  - rd_x_data <= value of rd_x_addr.
  - rd_x_ready <= ~pending_next[rd_x_addr].
  - When rd_x_en=0, both outputs hold.
- Read value rules:
  - Bypass: if a normal write to the same address occurs in the same cycle, rd_x_data takes wt_data.
  - ZERO_REG and address 0: data 0, ready 1.
  - Address >= DEPTH: data 0, ready 1.
- Scoreboard:
  - pending_next = (pending with the write bit cleared) with the lock bit set.
  - lock_busy = lock_en & pending[lock_addr] & ~(normal write to lock_addr this cycle).
  - A busy lock has no effect.
  - Locks to register 0 (ZERO_REG) or to out-of-range addresses are ignored with lock_busy=0.
- Simultaneous write and lock to the same address: the write stores data, the lock is accepted, and the bit ends at 1.
- Ports A and B may read the same address simultaneously; both get identical results.

Decomposition:
- Shared package gpr_pkg holds:
  - Defaults GPR_WIDTH=32 and GPR_DEPTH=16.
  - Function gpr_addr_valid(addr, depth, zero_reg), reporting writable/lockable.
  - Register-index constants: REG_ZERO=0.
- One sub-module, gpr_read_port: a registered read mux with bypass and ready logic, instantiated twice (A, B).
- Array and scoreboard stay in gpr_file.

Test Plan:
- Reset then read: pulse rst, rd_a_en=1, addr 5 -> next cycle rd_a_data=0, rd_a_ready=1, pending=0.
- Write then read: write 0xDEADBEEF to r3, next cycle read A=r3 and B=r3 -> both 0xDEADBEEF one cycle later.
- Bypass and zero register:
  - Same-cycle write 0x12345678 to r7 with rd_a_addr=7 -> rd_a_data=0x12345678 after one cycle.
  - Write 0xFFFFFFFF to r0 then read r0 -> 0.
- Scoreboard:
  - lock r4 -> pending[4]=1, read r4 gives ready=0.
  - Second lock r4 -> lock_busy=1, no change.
  - Write r4 -> pending[4]=0.
  - Same-cycle write+lock r4 -> lock_busy=0, pending[4]=1.
- Through mode: wt_en=1, through_en=1, addr 2, data 0xA5A5A5A5 -> through_data=0xA5A5A5A5, r2 unchanged, pending[2] unchanged.
- Reset mid-operation and out of range:
  - Assert rst between clk edges while writes/locks active -> immediate all-zero state.
  - DEPTH=12: write addr 13 -> no change; read addr 13 -> data 0, ready 1.
